// File: rtl/i2c_target_regfile_if.sv
// Bus bundle for i2c_target_regfile: I2C pad signals, register write strobe and host read port.
// reg_we is a single-clk strobe qualifying reg_waddr/reg_wdata; there is no back-pressure.
interface i2c_target_regfile_if #(
  parameter int N     = 8,
  parameter int DEPTH = 16
);
  localparam int PW = $clog2(DEPTH);

  logic          scl;
  logic          sda;
  logic          sda_pull;
  logic          reg_we;
  logic [PW-1:0] reg_waddr;
  logic [N-1:0]  reg_wdata;
  logic [PW-1:0] host_raddr;
  logic [N-1:0]  host_rdata;
  logic          busy;
  logic [3:0]    dbg_state;

  modport slave (
    input  scl, sda, host_raddr,
    output sda_pull, reg_we, reg_waddr, reg_wdata, host_rdata, busy, dbg_state
  );

  modport master (
    output scl, sda, host_raddr,
    input  sda_pull, reg_we, reg_waddr, reg_wdata, host_rdata, busy, dbg_state
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a DEPTH x N register file with an auto-incrementing pointer.
// Define I2C_TARGET_LSB_FIRST_EN to move every byte LSB first (R/W leads the address byte).
module i2c_target_regfile #(
  parameter int         N        = 8,
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_target_regfile_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          pull_q, pull_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          we_q, we_d;
  logic [PW-1:0] waddr_q, waddr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  regs [DEPTH];
  logic [N-1:0]  rd_byte;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] s, input logic b);
`ifdef I2C_TARGET_LSB_FIRST_EN
    return {b, s[N-1:1]};
`else
    return {s[N-2:0], b};
`endif
  endfunction

  function automatic logic out_bit(input logic [N-1:0] s);
`ifdef I2C_TARGET_LSB_FIRST_EN
    return s[0];
`else
    return s[N-1];
`endif
  endfunction

  function automatic logic [N-1:0] shift_out(input logic [N-1:0] s);
`ifdef I2C_TARGET_LSB_FIRST_EN
    return {1'b0, s[N-1:1]};
`else
    return {s[N-2:0], 1'b0};
`endif
  endfunction

  // Synchronizers idle high so reset release never looks like a START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= bus.scl; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= bus.sda; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rd_byte   = regs[ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    pull_d  = pull_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (stop_det) begin
      state_d = IDLE;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            sh_d  = shift_in(sh_q, sda_s2);
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d  = '0;
            pull_d = 1'b1;
            if (state_q == ADDR) begin
              // Both bit orders leave R/W in bit 0 and the address in [7:1].
              if (sh_q[N-1:1] == DEV_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = sh_q[0];
                state_d = ADDR_ACK;
              end else begin
                pull_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end else if (state_q == PTR) begin
              ptr_d   = sh_q[PW-1:0];
              state_d = PTR_ACK;
            end else begin
              we_d    = 1'b1;
              waddr_d = ptr_q;
              wdata_d = sh_q;
              ptr_d   = ptr_q + PW'(1);
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              pull_d  = ~out_bit(rd_byte);
              sh_d    = shift_out(rd_byte);
              cnt_d   = 4'd1;
              state_d = RDATA;
            end else begin
              pull_d  = 1'b0;
              cnt_d   = '0;
              state_d = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            pull_d  = 1'b0;
            cnt_d   = '0;
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q < 4'd8) begin
              pull_d = ~out_bit(sh_q);
              sh_d   = shift_out(sh_q);
              cnt_d  = cnt_q + 4'd1;
            end else begin
              pull_d  = 1'b0;
              ptr_d   = ptr_q + PW'(1);
              state_d = RDATA_ACK;
            end
          end
        end
        RDATA_ACK: begin
          // A NACK parks in IDLE, which ignores everything but START/STOP.
          if (scl_rise && sda_s2) begin
            state_d = IDLE;
          end else if (scl_fall) begin
            pull_d  = ~out_bit(rd_byte);
            sh_d    = shift_out(rd_byte);
            cnt_d   = 4'd1;
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      pull_q  <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      pull_q  <= pull_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // The array updates on the edge that raises reg_we, so a same-clk host read sees the old byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we_d) begin
      regs[waddr_d] <= wdata_d;
    end
  end

  assign bus.sda_pull   = pull_q;
  assign bus.reg_we     = we_q;
  assign bus.reg_waddr  = waddr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.host_rdata = regs[bus.host_raddr];
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, register-file model and write-strobe log.
module tb_i2c_target_regfile;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_sda = 1'b1;

  i2c_target_regfile_if #(.N(8), .DEPTH(DEPTH)) bus();
  assign bus.sda = m_sda & ~bus.sda_pull;

  i2c_target_regfile #(.N(8), .DEV_ADDR(7'h50), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [DEPTH];
  int          ptr_m;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];
  logic [7:0]  ebuf [8];

  always @(negedge clk) begin
    if (rst && bus.reg_we) got_q.push_back({bus.reg_waddr, bus.reg_wdata});
  end

  function automatic int bit_pos(input int i);
`ifdef I2C_TARGET_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  task automatic qd();
    repeat (6) @(negedge clk);
  endtask

  task automatic start_cond();
    m_sda = 1'b1; qd();
    bus.scl = 1'b1; qd();
    m_sda = 1'b0; qd();
    bus.scl = 1'b0; qd();
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; qd();
    bus.scl = 1'b1; qd();
    m_sda = 1'b1; qd();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 0; i < 8; i++) begin
      m_sda = b[bit_pos(i)]; qd();
      bus.scl = 1'b1; qd(); qd();
      bus.scl = 1'b0; qd();
    end
    m_sda = 1'b1; qd();
    bus.scl = 1'b1; qd();
    acked = (bus.sda === 1'b0);
    qd();
    bus.scl = 1'b0; qd();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bus.scl = 1'b1; qd();
      b[bit_pos(i)] = bus.sda;
      qd();
      bus.scl = 1'b0; qd();
    end
    m_sda = nack; qd();
    bus.scl = 1'b1; qd(); qd();
    bus.scl = 1'b0; qd();
    m_sda = 1'b1;
  endtask

  // Full write: address, pointer byte, then n data bytes from wbuf; model tracks the effect.
  task automatic write_txn(input logic [7:0] p, input int n, output int nacks);
    logic a;
    nacks = 0;
    start_cond();
    send_byte(8'hA0, a); if (!a) nacks++;
    send_byte(p, a);     if (!a) nacks++;
    ptr_m = int'(p) % DEPTH;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a); if (!a) nacks++;
      mem_m[ptr_m] = wbuf[i];
      exp_q.push_back({4'(ptr_m), wbuf[i]});
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    stop_cond();
  endtask

  // Read n bytes (last one NACKed), optionally after setting the pointer with a repeated START.
  task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n,
                          output int nacks, output logic pull_after);
    logic a;
    nacks = 0;
    start_cond();
    if (set_ptr) begin
      send_byte(8'hA0, a); if (!a) nacks++;
      send_byte(p, a);     if (!a) nacks++;
      ptr_m = int'(p) % DEPTH;
      start_cond();
    end
    send_byte(8'hA1, a); if (!a) nacks++;
    for (int i = 0; i < n; i++) begin
      ebuf[i] = mem_m[ptr_m];
      ptr_m = (ptr_m + 1) % DEPTH;
      recv_byte(i == n - 1, rbuf[i]);
    end
    qd();
    pull_after = bus.sda_pull;
    stop_cond();
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.scl = 1'b1;
    m_sda = 1'b1;
    bus.host_raddr = '0;
    model_reset();
    repeat (4) @(negedge clk);
    checks++; if (bus.sda_pull !== 1'b0) begin errors++; $display("FAIL reset_sda_pull got %b exp 0", bus.sda_pull); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b exp 0", bus.reg_we); end
    checks++; if (bus.reg_waddr !== 4'h0) begin errors++; $display("FAIL reset_waddr got %h exp 0", bus.reg_waddr); end
    checks++; if (bus.reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", bus.reg_wdata); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      bus.host_raddr = 4'(i); #1;
      checks++;
      if (bus.host_rdata !== mem_m[i]) begin errors++; $display("FAIL reset_reg[%0d] got %h exp %h", i, bus.host_rdata, mem_m[i]); end
    end
  endtask

  task automatic test_basic_write();
    logic a;
    int nacks;
    logic [11:0] e, g;
    nacks = 0;
    start_cond();
    send_byte(8'hA0, a); if (!a) nacks++;
    send_byte(8'h03, a); if (!a) nacks++;
    send_byte(8'h5A, a); if (!a) nacks++;
    mem_m[3] = 8'h5A; ptr_m = 4;
    exp_q.push_back({4'h3, 8'h5A});
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_high got %b exp 1", bus.busy); end
    stop_cond();
    checks++; if (nacks !== 0) begin errors++; $display("FAIL basic_acks got %0d nacks exp 0", nacks); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop got %b exp 0", bus.busy); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_we_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL basic_we got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    bus.host_raddr = 4'h3; #1;
    checks++; if (bus.host_rdata !== 8'h5A) begin errors++; $display("FAIL basic_host_rdata got %h exp 5a", bus.host_rdata); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    start_cond();
    send_byte(8'hA2, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack got %b exp 0", a); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy got %b exp 0", bus.busy); end
    send_byte(8'h07, a);
    send_byte(8'hEE, a);
    stop_cond();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL wrong_addr_we got %0d exp 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_wrap();
    int nacks;
    logic [11:0] e, g;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(8'h0F, 2, nacks);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL wrap_acks got %0d exp 0", nacks); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_we_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL wrap_we got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    bus.host_raddr = 4'hF; #1;
    checks++; if (bus.host_rdata !== 8'h11) begin errors++; $display("FAIL wrap_reg15 got %h exp 11", bus.host_rdata); end
    bus.host_raddr = 4'h0; #1;
    checks++; if (bus.host_rdata !== 8'h22) begin errors++; $display("FAIL wrap_reg0 got %h exp 22", bus.host_rdata); end
  endtask

  task automatic test_read_rs();
    int nacks;
    logic pull_after;
    wbuf[0] = 8'hC3; wbuf[1] = 8'h96;
    write_txn(8'h02, 2, nacks);
    exp_q.delete(); got_q.delete();
    read_txn(1'b1, 8'h02, 2, nacks, pull_after);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL read_rs_acks got %0d exp 0", nacks); end
    checks++; if (rbuf[0] !== 8'hC3) begin errors++; $display("FAIL read_rs_byte0 got %h exp c3", rbuf[0]); end
    checks++; if (rbuf[1] !== 8'h96) begin errors++; $display("FAIL read_rs_byte1 got %h exp 96", rbuf[1]); end
    checks++; if (pull_after !== 1'b0) begin errors++; $display("FAIL read_rs_release got %b exp 0", pull_after); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL read_rs_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_random();
    int nacks, n;
    logic pull_after, sp;
    logic [7:0] p;
    logic [11:0] e, g;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      p = 8'($urandom);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(p, n, nacks);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rand_write_acks it %0d got %0d exp 0", it, nacks); end
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_we_count it %0d got %0d exp %0d", it, got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (g !== e) begin errors++; $display("FAIL rand_we it %0d got %h exp %h", it, g, e); end
      end
      exp_q.delete(); got_q.delete();
      sp = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      read_txn(sp, 8'($urandom), n, nacks, pull_after);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rand_read_acks it %0d got %0d exp 0", it, nacks); end
      for (int i = 0; i < n; i++) begin
        checks++; if (rbuf[i] !== ebuf[i]) begin errors++; $display("FAIL rand_read it %0d byte %0d got %h exp %h", it, i, rbuf[i], ebuf[i]); end
      end
      checks++; if (pull_after !== 1'b0) begin errors++; $display("FAIL rand_release it %0d got %b exp 0", it, pull_after); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.host_raddr = 4'(i); #1;
      checks++; if (bus.host_rdata !== mem_m[i]) begin errors++; $display("FAIL rand_host reg[%0d] got %h exp %h", i, bus.host_rdata, mem_m[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int nacks;
    logic a;
    logic [11:0] e, g;
    wbuf[0] = 8'h00;
    write_txn(8'h05, 1, nacks);
    exp_q.delete(); got_q.delete();
    start_cond();
    send_byte(8'hA0, a);
    send_byte(8'h05, a);
    start_cond();
    send_byte(8'hA1, a);
    checks++; if (bus.sda_pull !== 1'b1) begin errors++; $display("FAIL mid_pull_before got %b exp 1", bus.sda_pull); end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.sda_pull !== 1'b0) begin errors++; $display("FAIL mid_pull_async got %b exp 0", bus.sda_pull); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    write_txn(8'($urandom), 2, nacks);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL mid_after_acks got %0d exp 0", nacks); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_we_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL mid_we got %h exp %h", g, e); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.host_raddr = 4'(i); #1;
      checks++; if (bus.host_rdata !== mem_m[i]) begin errors++; $display("FAIL mid_host reg[%0d] got %h exp %h", i, bus.host_rdata, mem_m[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_wrap();
    test_read_rs();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 Parameter N, default 8: data byte width; only 8 is supported.
REQ-002 Parameter DEV_ADDR, default 7'h50: 7-bit target address this block answers to.
REQ-003 Parameter DEPTH, default 16: register count, power of two; pointer width PW = log2(DEPTH).
REQ-004 clk  input  1  system clock; all logic SHALL be clocked on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 scl  input  1  I2C clock from the master, asynchronous to clk.
REQ-007 sda  input  1  I2C data line as seen at the pad.
REQ-008 sda_pull  output  1  1 = drive SDA low (open-drain); 0 = release.
REQ-009 reg_we  output  1  one-clk pulse when a register is written.
REQ-010 reg_waddr  output  PW  index written on reg_we.
REQ-011 reg_wdata  output  N  byte written on reg_we.
REQ-012 host_raddr  input  PW  host-side read index.
REQ-013 host_rdata  output  N  combinational read of the register at host_raddr.
REQ-014 busy  output  1  high from an address-matched START until STOP.

Function
REQ-015 scl and sda SHALL each pass a 2-flop synchronizer; all edge detection SHALL use the synchronized copies; edge detect SHALL add 1 clk.
REQ-016 START (sda fall while scl high) SHALL force state ADDR and clear the bit counter from any state, including repeated START.
REQ-017 STOP (sda rise while scl high) SHALL force IDLE, release sda_pull, and clear busy within 1 clk of detection.
REQ-018 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-019 Received bits SHALL be sampled on synchronized scl rise; sda_pull SHALL change only on synchronized scl fall, never while scl is high except after STOP.
REQ-020 ADDR: shift 8 bits (7 address + R/W, R/W last); on match, at the 8th scl fall assert sda_pull (ACK), set busy, go to ADDR_ACK. On mismatch, release and return to IDLE.
REQ-021 ADDR_ACK: release at the 9th scl fall; W -> PTR, R -> RDATA with the bit at reg[ptr] driven (sda_pull = ~bit).
REQ-022 PTR: the first write byte SHALL load ptr (low PW bits; upper bits ignored), followed by ACK in PTR_ACK, then WDATA.
REQ-023 WDATA: at the 8th bit, pulse reg_we with reg_waddr = ptr and reg_wdata = byte, write the register, ACK, then ptr += 1 modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-024 RDATA: drive 8 bits of reg[ptr], then release for the master ACK bit; ptr += 1 modulo DEPTH after the byte.
REQ-025 RDATA_ACK: sample at the 9th scl rise; ACK (0) -> RDATA with the next byte; NACK (1) -> IDLE-wait (released) until STOP/START.
REQ-026 ptr SHALL persist across transactions, so a read without a PTR phase continues from the last ptr.
REQ-027 A host read SHALL return the value written in the prior clk; a same-clk write/read SHALL return the old value.

Reset
REQ-028 With rst low: state = IDLE, sda_pull = 0, reg_we = 0, reg_waddr = 0, reg_wdata = 0, busy = 0, ptr = 0, all registers = 0, synchronizers = 1.
REQ-029 Reset mid-transaction SHALL release SDA immediately (asynchronously); the block SHALL ignore the bus until the next START.

Configuration
REQ-030 Macro I2C_TARGET_LSB_FIRST_EN: when defined, every byte (address, pointer, data, read) SHALL be transferred LSB first, with R/W as the first bit of the address byte; when undefined, bytes SHALL be MSB first with R/W last (standard I2C).

Verification
REQ-031 Write 0xA0 (addr 0x50, W), ptr 0x03, data 0x5A, STOP -> ACK on all 3 bytes; reg_we pulses once with waddr 3 / wdata 0x5A; host_rdata at index 3 = 0x5A; busy low after STOP.
REQ-032 Address 0x51 W -> no ACK (SDA released at 9th clock); no reg_we; busy stays 0.
REQ-033 ptr 0x0F, data 0x11, 0x22 -> reg[15] = 0x11, reg[0] = 0x22 (wrap).
REQ-034 Write ptr 0x02, repeated START, read 0x50 R, 2 bytes with ACK then NACK -> returns reg[2], reg[3]; SDA released after NACK; STOP -> IDLE.
REQ-035 rst asserted low mid-data-byte while sda_pull = 1 -> sda_pull = 0 the same cycle; the next full write transaction succeeds.
